alu_seq_adder: RTL and testbench
================================

Name: alu_seq_adder

Overview:
Parametrised, multi-cycle successor to the ALU's 16-bit combinational adder.
- Computes ADD/ADC/SUB/SBC over WIDTH bits, SLICE bits per clock, using a registered carry between slices.
- Produces AVR-style status flags (C, Z, N, V, H).
- Sits beside the ALU for wide or area-constrained arithmetic: long-word ops, and the multiply/divide helpers that trade latency for area.

Parameters:
WIDTH  16  operand/result width; must be ≥ 8 and a multiple of SLICE
SLICE  4   bits added per clock; NSLICE = WIDTH/SLICE (1..WIDTH)

Ports:
cp2     in   1      clock, all state on rising edge
ireset  in   1      asynchronous active-low reset
start   in   1      request; sampled only when busy=0
op      in   2      00 ADD, 01 ADC, 10 SUB, 11 SBC
a       in   WIDTH  operand A
b       in   WIDTH  operand B
ci      in   1      carry/borrow in (used by ADC/SBC only)
z_in    in   1      previous Z flag (used by SBC only)
busy    out  1      operation in progress
done    out  1      one-cycle pulse, results valid
s       out  WIDTH  result
co      out  1      C flag: carry (ADD/ADC) or borrow (SUB/SBC)
z       out  1      Z flag
n       out  1      N flag = s[WIDTH-1]
v       out  1      two's-complement overflow
h       out  1      H flag: carry/borrow out of bit 3

Behaviour:
Reset (ireset=0, asynchronous, any time including mid-operation):
- busy=0, done=0, s=0, co=0, z=0, n=0, v=0, h=0.
- Slice counter and internal carry cleared; the in-flight operation is discarded.

Accept:
- Rising edge with start=1 and busy=0 latches a, b, op, ci and z_in; busy=1 from the next cycle.
- start while busy=1 is ignored and has no effect on the current operation.
- start in the done cycle is accepted, because busy=0 then. Back-to-back throughput is one op per NSLICE+1 cycles.

Operand conditioning at latch:
- ADD: B'=b, cin=0.
- ADC: B'=b, cin=ci.
- SUB: B'=~b, cin=1.
- SBC: B'=~b, cin=~ci.

Execution:
- Edges 1..NSLICE after the start edge each process slice k = edge−1, i.e. bits [k*SLICE +: SLICE], LSB slice first.
- Slice carry-out is registered as the next slice's carry-in.
- The partial sum accumulates in an internal register.
- Carry out of bit 3 is captured as the raw half-carry in whichever slice contains bit 3.
- Carries into and out of bit WIDTH−1 are retained for V.

Completion, at edge NSLICE (the same edge that processes the last slice):
- busy→0 and done→1 for exactly one cycle.
- s, co, z, n, v and h update together. Outputs change only at the completion edge; partial sums are never visible.
- Outputs hold until the next completion or reset.
- Latency: done is high NSLICE cycles after the start edge (1 cycle when SLICE=WIDTH).

Flags:
- co: ADD/ADC = carry out of MSB; SUB/SBC = inverted carry out (borrow).
- h: ADD/ADC = raw carry out of bit 3; SUB/SBC = inverted.
- v = carry into MSB XOR carry out of MSB.
- n = s[WIDTH−1].
- z: ADD/ADC/SUB = (s==0); SBC = (s==0) AND latched z_in.

Arithmetic is modulo 2^WIDTH; no other wrap-around or saturation.

FSM: IDLE (busy=0) → RUN (counter 0..NSLICE−1) → IDLE, with the done pulse on entry to IDLE. No other states.

Test Plan:
(All with WIDTH=16, SLICE=4 unless stated.)
- ADD a=0x7FFF b=0x0001 → done exactly 4 cycles after start edge; s=0x8000, co=0, z=0, n=1, v=1, h=1; busy high 4 cycles.
- SUB a=0x0000 b=0x0001 → s=0xFFFF, co=1, n=1, v=0, h=1, z=0. ADC a=0xFFFF b=0x0000 ci=1 → s=0x0000, co=1, z=1, h=1, v=0.
- SBC a=0x1234 b=0x1234 ci=0: with z_in=0 → s=0x0000, z=0, co=0; repeat with z_in=1 → z=1. SBC a=0x0000 b=0x0000 ci=1 → s=0xFFFF, co=1.
- Pulse start again 2 cycles into an op with different operands → ignored, original result produced. Start in the done cycle → second op accepted, done again 4 cycles later.
- Drop ireset low 2 cycles into an op → all outputs 0 immediately (asynchronously, before next edge). After release: no done pulse, and next start works normally.
- Re-run the first two scenarios with SLICE=16 (latency 1) and with WIDTH=32, SLICE=8 (a=0xFFFFFFFF b=1 ADD → s=0, co=1, z=1, latency 4). Random ops are compared against a reference model across all parameter sets.

Source files
------------

// File: rtl/alu_seq_adder_if.sv
// Request/response bundle for the slice-serial adder: operands and op code in,
// handshake and registered result/flags out.
interface alu_seq_adder_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ci;
  logic             z_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             co;
  logic             z;
  logic             n;
  logic             v;
  logic             h;

  modport master (
    output start, op, a, b, ci, z_in,
    input  busy, done, s, co, z, n, v, h
  );

  modport slave (
    input  start, op, a, b, ci, z_in,
    output busy, done, s, co, z, n, v, h
  );
endinterface

// File: rtl/alu_seq_adder.sv
// Multi-cycle ADD/ADC/SUB/SBC: SLICE bits per clock with a registered carry
// between slices, AVR-style C/Z/N/V/H flags published only at completion.
module alu_seq_adder #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic          cp2,
  input  logic          ireset,
  alu_seq_adder_if.slave bus
);
  localparam int NSLICE = WIDTH / SLICE;
  localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam int HSLICE = 3 / SLICE;
  localparam int HBIT   = 3 % SLICE;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NSLICE - 1);
  localparam logic [CNT_W-1:0] H_CNT    = CNT_W'(HSLICE);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             carry_reg;
  logic             sub_reg;
  logic             sbc_reg;
  logic             zin_reg;
  logic             h_raw_reg;
  logic             busy_reg;
  logic             done_reg;
  logic [WIDTH-1:0] s_reg;
  logic             co_reg;
  logic             z_reg;
  logic             n_reg;
  logic             v_reg;
  logic             h_reg;

  logic [SLICE:0]   c;
  logic [SLICE-1:0] slice_sum;
  logic [WIDTH-1:0] sum_next;
  logic [WIDTH-1:0] b_next;
  logic             cin_next;
  logic             h_raw_next;

  // Operands shift right each step, so the active slice is always the low SLICE bits.
  assign c[0] = carry_reg;
  generate
    for (genvar gi = 0; gi < SLICE; gi++) begin : g_bit
      assign slice_sum[gi] = a_reg[gi] ^ b_reg[gi] ^ c[gi];
      assign c[gi+1]       = (a_reg[gi] & b_reg[gi]) | (c[gi] & (a_reg[gi] ^ b_reg[gi]));
    end
  endgenerate

  // New slice enters at the top; after NSLICE steps the full result is aligned.
  assign sum_next   = WIDTH'({slice_sum, sum_reg} >> SLICE);
  assign h_raw_next = (cnt_reg == H_CNT) ? c[HBIT+1] : h_raw_reg;
  assign b_next     = bus.op[1] ? ~bus.b : bus.b;

  always_comb begin
    cin_next = 1'b0;
    case (bus.op)
      2'b00:   cin_next = 1'b0;
      2'b01:   cin_next = bus.ci;
      2'b10:   cin_next = 1'b1;
      default: cin_next = ~bus.ci;
    endcase
  end

  always_ff @(posedge cp2 or negedge ireset) begin
    if (!ireset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      sub_reg   <= 1'b0;
      sbc_reg   <= 1'b0;
      zin_reg   <= 1'b0;
      h_raw_reg <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      s_reg     <= '0;
      co_reg    <= 1'b0;
      z_reg     <= 1'b0;
      n_reg     <= 1'b0;
      v_reg     <= 1'b0;
      h_reg     <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            a_reg     <= bus.a;
            b_reg     <= b_next;
            carry_reg <= cin_next;
            sub_reg   <= bus.op[1];
            sbc_reg   <= (bus.op == 2'b11);
            zin_reg   <= bus.z_in;
            cnt_reg   <= '0;
            busy_reg  <= 1'b1;
            state_reg <= RUN;
          end
        end
        RUN: begin
          a_reg     <= a_reg >> SLICE;
          b_reg     <= b_reg >> SLICE;
          carry_reg <= c[SLICE];
          sum_reg   <= sum_next;
          h_raw_reg <= h_raw_next;
          if (cnt_reg == LAST_CNT) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            s_reg     <= sum_next;
            co_reg    <= c[SLICE] ^ sub_reg;
            z_reg     <= (sum_next == '0) & (~sbc_reg | zin_reg);
            n_reg     <= sum_next[WIDTH-1];
            v_reg     <= c[SLICE] ^ c[SLICE-1];
            h_reg     <= h_raw_next ^ sub_reg;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.busy = busy_reg;
  assign bus.done = done_reg;
  assign bus.s    = s_reg;
  assign bus.co   = co_reg;
  assign bus.z    = z_reg;
  assign bus.n    = n_reg;
  assign bus.v    = v_reg;
  assign bus.h    = h_reg;
endmodule

// File: tb/tb_alu_seq_adder.sv
// Bench for alu_seq_adder across three parameter sets (16/4, 16/16, 32/8):
// spec vectors, multi-cycle corner sequences and random ops vs. an arithmetic model.
module tb_alu_seq_adder;
  logic        clk = 1'b0;
  logic        ireset = 1'b0;
  logic [2:0]  start_v = '0;
  logic [1:0]  op_v = '0;
  logic [31:0] a_v = '0;
  logic [31:0] b_v = '0;
  logic        ci_v = 1'b0;
  logic        zin_v = 1'b0;

  logic        busy_o [3];
  logic        done_o [3];
  logic [31:0] s_o [3];
  logic [4:0]  flags_o [3];  // {co, z, n, v, h}

  int checks = 0;
  int errors = 0;
  int wdt[3] = '{16, 16, 32};
  int nsl[3] = '{4, 1, 4};

  always #5 clk = ~clk;

  alu_seq_adder_if #(.WIDTH(16)) if0 ();
  alu_seq_adder_if #(.WIDTH(16)) if1 ();
  alu_seq_adder_if #(.WIDTH(32)) if2 ();

  alu_seq_adder #(.WIDTH(16), .SLICE(4))  dut0 (.cp2(clk), .ireset(ireset), .bus(if0));
  alu_seq_adder #(.WIDTH(16), .SLICE(16)) dut1 (.cp2(clk), .ireset(ireset), .bus(if1));
  alu_seq_adder #(.WIDTH(32), .SLICE(8))  dut2 (.cp2(clk), .ireset(ireset), .bus(if2));

  assign if0.start = start_v[0];
  assign if1.start = start_v[1];
  assign if2.start = start_v[2];
  assign if0.op = op_v;  assign if1.op = op_v;  assign if2.op = op_v;
  assign if0.a = a_v[15:0];  assign if1.a = a_v[15:0];  assign if2.a = a_v;
  assign if0.b = b_v[15:0];  assign if1.b = b_v[15:0];  assign if2.b = b_v;
  assign if0.ci = ci_v;  assign if1.ci = ci_v;  assign if2.ci = ci_v;
  assign if0.z_in = zin_v;  assign if1.z_in = zin_v;  assign if2.z_in = zin_v;

  assign busy_o[0] = if0.busy;  assign busy_o[1] = if1.busy;  assign busy_o[2] = if2.busy;
  assign done_o[0] = if0.done;  assign done_o[1] = if1.done;  assign done_o[2] = if2.done;
  assign s_o[0] = {16'h0, if0.s};
  assign s_o[1] = {16'h0, if1.s};
  assign s_o[2] = if2.s;
  assign flags_o[0] = {if0.co, if0.z, if0.n, if0.v, if0.h};
  assign flags_o[1] = {if1.co, if1.z, if1.n, if1.v, if1.h};
  assign flags_o[2] = {if2.co, if2.z, if2.n, if2.v, if2.h};

  typedef struct {
    int          inst;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        ci;
    logic        zin;
    logic [31:0] es;
    logic [4:0]  ef;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Whole-word arithmetic: result, borrow and overflow straight from the op definitions.
  function automatic void model(input int w, input logic [1:0] op, input logic [31:0] a,
                                input logic [31:0] b, input logic ci, input logic zin,
                                output logic [31:0] s, output logic [4:0] f);
    longint unsigned mask = (64'd1 << w) - 1;
    longint unsigned ua = a & mask;
    longint unsigned ub = b & mask;
    longint unsigned k  = (op == 2'b01 || op == 2'b11) ? longint'(ci) : 0;
    longint unsigned full;
    logic co, z, n, v, h, sa, sb, sr;
    if (!op[1]) begin
      full = ua + ub + k;
      co   = ((full >> w) & 1) != 0;
      h    = ((ua & 15) + (ub & 15) + k) > 15;
    end else begin
      full = ua - ub - k;
      co   = ua < (ub + k);
      h    = (ua & 15) < ((ub & 15) + k);
    end
    s  = 32'(full & mask);
    sa = a[w-1];
    sb = b[w-1];
    sr = s[w-1];
    v  = op[1] ? ((sa != sb) && (sr != sa)) : ((sa == sb) && (sr != sa));
    n  = sr;
    z  = (s == 0) && (op != 2'b11 || zin);
    f  = {co, z, n, v, h};
  endfunction

  task automatic wait_done(input int inst, inout int lat);
    while (!done_o[inst] && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check($sformatf("done_seen%0d", inst), 64'(done_o[inst]), 64'd1);
  endtask

  task automatic run_op(input int inst, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic ci, input logic zin,
                        input logic [31:0] es, input logic [4:0] ef, input string name);
    int lat = 0;
    op_v = op; a_v = a; b_v = b; ci_v = ci; zin_v = zin;
    start_v[inst] = 1'b1;
    @(posedge clk); #1;
    start_v[inst] = 1'b0;
    check({name, "_busy"}, 64'(busy_o[inst]), 64'd1);
    wait_done(inst, lat);
    $display("%s inst=%0d op=%0d a=%h b=%h ci=%0b zin=%0b -> s=%h cznvh=%b lat=%0d",
             name, inst, op, a, b, ci, zin, s_o[inst], flags_o[inst], lat);
    check({name, "_lat"}, 64'(lat), 64'(nsl[inst]));
    check({name, "_busy_at_done"}, 64'(busy_o[inst]), 64'd0);
    check({name, "_result"}, {27'h0, flags_o[inst], s_o[inst]}, {27'h0, ef, es});
    @(posedge clk); #1;
    check({name, "_done_1cyc"}, 64'(done_o[inst]), 64'd0);
  endtask

  initial begin
    vec_t        tbl[$];
    int          lat;
    logic        seen;
    logic [31:0] ms;
    logic [4:0]  mf;

    tbl.push_back('{0, 2'b00, 32'h7FFF, 32'h0001, 1'b0, 1'b0, 32'h8000, 5'b00111});
    tbl.push_back('{0, 2'b10, 32'h0000, 32'h0001, 1'b0, 1'b0, 32'hFFFF, 5'b10101});
    tbl.push_back('{0, 2'b01, 32'hFFFF, 32'h0000, 1'b1, 1'b0, 32'h0000, 5'b11001});
    tbl.push_back('{0, 2'b11, 32'h1234, 32'h1234, 1'b0, 1'b0, 32'h0000, 5'b00000});
    tbl.push_back('{0, 2'b11, 32'h1234, 32'h1234, 1'b0, 1'b1, 32'h0000, 5'b01000});
    tbl.push_back('{0, 2'b11, 32'h0000, 32'h0000, 1'b1, 1'b0, 32'hFFFF, 5'b10101});
    tbl.push_back('{1, 2'b00, 32'h7FFF, 32'h0001, 1'b0, 1'b0, 32'h8000, 5'b00111});
    tbl.push_back('{1, 2'b10, 32'h0000, 32'h0001, 1'b0, 1'b0, 32'hFFFF, 5'b10101});
    tbl.push_back('{2, 2'b00, 32'hFFFFFFFF, 32'h1, 1'b0, 1'b0, 32'h0, 5'b11001});
    tbl.push_back('{2, 2'b10, 32'h0, 32'h1, 1'b0, 1'b0, 32'hFFFFFFFF, 5'b10101});
    tbl.push_back('{2, 2'b00, 32'h7FFFFFFF, 32'h1, 1'b0, 1'b0, 32'h80000000, 5'b00111});

    #12;
    for (int i = 0; i < 3; i++)
      check($sformatf("reset_state%0d", i),
            {25'h0, busy_o[i], done_o[i], flags_o[i], s_o[i]}, 64'd0);
    @(negedge clk); ireset = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < tbl.size(); i++)
      run_op(tbl[i].inst, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].ci, tbl[i].zin,
             tbl[i].es, tbl[i].ef, $sformatf("vec%0d", i));

    // start while busy must not disturb the op already in flight
    op_v = 2'b00; a_v = 32'h0100; b_v = 32'h0023; ci_v = 1'b0; zin_v = 1'b0;
    start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    lat = 0;
    repeat (2) begin @(posedge clk); #1; lat++; end
    op_v = 2'b10; a_v = 32'hFFFF; b_v = 32'hFFFF; start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    lat++;
    wait_done(0, lat);
    $display("ignore_start s=%h cznvh=%b lat=%0d", s_o[0], flags_o[0], lat);
    check("ignore_lat", 64'(lat), 64'd4);
    check("ignore_result", {27'h0, flags_o[0], s_o[0]}, {27'h0, 5'b00000, 32'h0123});

    // start in the done cycle is accepted
    op_v = 2'b00; a_v = 32'h8000; b_v = 32'h8000; start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    check("b2b_busy", 64'(busy_o[0]), 64'd1);
    lat = 0;
    wait_done(0, lat);
    $display("back_to_back s=%h cznvh=%b lat=%0d", s_o[0], flags_o[0], lat);
    check("b2b_lat", 64'(lat), 64'd4);
    check("b2b_result", {27'h0, flags_o[0], s_o[0]}, {27'h0, 5'b11010, 32'h0000});

    // asynchronous reset mid-operation clears outputs before any clock edge
    op_v = 2'b00; a_v = 32'h0001; b_v = 32'h0001; start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    ireset = 1'b0;
    #1;
    $display("async_reset s=%h cznvh=%b busy=%0b done=%0b", s_o[0], flags_o[0], busy_o[0], done_o[0]);
    check("async_reset_out", {25'h0, busy_o[0], done_o[0], flags_o[0], s_o[0]}, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); ireset = 1'b1;
    seen = 1'b0;
    repeat (8) begin @(posedge clk); #1; seen = seen | done_o[0]; end
    check("no_done_after_reset", 64'(seen), 64'd0);
    run_op(0, 2'b00, 32'h0F0F, 32'h0101, 1'b0, 1'b0, 32'h1010, 5'b00001, "post_reset");

    for (int i = 0; i < 60; i++) begin
      int          inst = int'($urandom_range(0, 2));
      logic [1:0]  op   = 2'($urandom_range(0, 3));
      logic [31:0] a    = $urandom;
      logic [31:0] b    = $urandom;
      logic        ci   = 1'($urandom_range(0, 1));
      logic        zin  = 1'($urandom_range(0, 1));
      if (wdt[inst] == 16) begin a[31:16] = '0; b[31:16] = '0; end
      model(wdt[inst], op, a, b, ci, zin, ms, mf);
      run_op(inst, op, a, b, ci, zin, ms, mf, $sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
